// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase accumulator: default widths, config
// address map and the dither LFSR constants/step function.
package dds_pkg;

   localparam int DDS_ACC_W   = 24;
   localparam int DDS_PHASE_W = 14;

   // cfg_addr map: three little-endian FTW bytes, then the phase offset byte
   typedef enum logic [1:0] {
      ADDR_FTW0 = 2'd0,
      ADDR_FTW1 = 2'd1,
      ADDR_FTW2 = 2'd2,
      ADDR_OFF  = 2'd3
   } cfg_addr_e;

   localparam int          LFSR_W    = 16;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/dds_lfsr.sv
// 16-bit Galois LFSR used as the phase-truncation dither source.
// Only instantiated when DDS_PHASE_DITHER_EN is defined.
module dds_lfsr
   import dds_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   output logic [LFSR_W-1:0] out
);

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;

   // Advance one state per step, otherwise hold
   always_comb begin
      lfsr_d = lfsr_q;
      if (step) lfsr_d = lfsr_next(lfsr_q);
   end

   // State register, reseeded on reset (the all-zero state would lock up)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_d;
   end

   assign out = lfsr_q;

endmodule

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator (NCO core). Byte-loadable shadow FTW/offset registers
// committed atomically, sync clear, wrap pulse on accumulator carry-out.
// Optional build macro: DDS_PHASE_DITHER_EN adds LFSR dither ahead of the
// phase truncation (requires ACC_W - PHASE_W between 1 and 16).
module dds_phase_accum
   import dds_pkg::*;
#(
   parameter int ACC_W   = DDS_ACC_W,   // multiple of 8, >= PHASE_W
   parameter int PHASE_W = DDS_PHASE_W  // > 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ena,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [7:0]         cfg_data,
   input  logic               commit,
   input  logic               sync,
   output logic [PHASE_W-1:0] phase,
   output logic               wrap
);

   logic [ACC_W-1:0]   ftw_sh_q, ftw_sh_d;
   logic [7:0]         off_sh_q, off_sh_d;
   logic [ACC_W-1:0]   ftw_q, ftw_d;
   logic [7:0]         off_q, off_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic               wrap_q, wrap_d;

   logic [ACC_W:0]     acc_sum;
   logic [ACC_W-1:0]   acc_src;
   logic [PHASE_W-1:0] off_ext;

`ifdef DDS_PHASE_DITHER_EN
   logic [LFSR_W-1:0] lfsr_out;
   logic [ACC_W-1:0]  dith_mask;

   dds_lfsr u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .step (ena),
      .out  (lfsr_out)
   );

   // Low (ACC_W-PHASE_W) LFSR bits land exactly on the truncated bits
   assign dith_mask = (ACC_W'(1) << (ACC_W - PHASE_W)) - ACC_W'(1);
   assign acc_src   = acc_q + (ACC_W'(lfsr_out) & dith_mask);
`else
   assign acc_src = acc_q;
`endif

   // The 8-bit offset is aligned to the top of the phase word
   assign off_ext = PHASE_W'(off_q) << (PHASE_W - 8);
   assign acc_sum = {1'b0, acc_q} + {1'b0, ftw_q};

   // Config path: shadow byte writes ignore ena; commit copies the pre-edge
   // shadow, so a write in the commit cycle waits for the next commit
   always_comb begin
      ftw_sh_d = ftw_sh_q;
      off_sh_d = off_sh_q;
      ftw_d    = ftw_q;
      off_d    = off_q;
      if (cfg_we) begin
         if (cfg_addr == ADDR_OFF) begin
            off_sh_d = cfg_data;
         end else begin
            for (int b = 0; b < ACC_W / 8; b++)
               if (int'(cfg_addr) == b) ftw_sh_d[b*8 +: 8] = cfg_data;
         end
      end
      if (commit) begin
         ftw_d = ftw_sh_q;
         off_d = off_sh_q;
      end
   end

   // Accumulate path: phase always comes from the pre-edge accumulator, sync
   // only clears the accumulator and suppresses the carry
   always_comb begin
      acc_d   = acc_q;
      phase_d = phase_q;
      wrap_d  = 1'b0;
      if (ena) begin
         phase_d = acc_src[ACC_W-1 -: PHASE_W] + off_ext;
         if (sync) begin
            acc_d = '0;
         end else begin
            acc_d  = acc_sum[ACC_W-1:0];
            wrap_d = acc_sum[ACC_W];
         end
      end
   end

   // All state registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ftw_sh_q <= '0;
         off_sh_q <= '0;
         ftw_q    <= '0;
         off_q    <= '0;
         acc_q    <= '0;
         phase_q  <= '0;
         wrap_q   <= 1'b0;
      end else begin
         ftw_sh_q <= ftw_sh_d;
         off_sh_q <= off_sh_d;
         ftw_q    <= ftw_d;
         off_q    <= off_d;
         acc_q    <= acc_d;
         phase_q  <= phase_d;
         wrap_q   <= wrap_d;
      end
   end

   assign phase = phase_q;
   assign wrap  = wrap_q;

endmodule

// File: doc/dds_phase_accum.md
# dds_phase_accum

Phase accumulator (NCO core) for the DDS. Sits directly upstream of the sine lookup stage and produces its 14-bit phase word every clock. Holds a byte-loadable frequency tuning word (FTW) and phase offset in shadow registers, then commits them atomically. Also provides a phase-sync clear and a wrap pulse usable as a square-wave or sync output.

## Interface
- ACC_W, 24, accumulator width; must be a multiple of 8 and ≥ PHASE_W
- PHASE_W, 14, output phase width, matching the sine stage's phase input
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- ena  in  1  accumulate enable
- cfg_we  in  1  byte write strobe into the shadow registers
- cfg_addr  in  2  0..2 = FTW bytes, little-endian (0 = bits 7:0); 3 = phase offset byte
- cfg_data  in  8  write data
- commit  in  1  copies shadow FTW and offset into the active registers
- sync  in  1  clears the accumulator
- phase  out  PHASE_W  registered phase to the sine stage
- wrap  out  1  one-cycle pulse on accumulator carry-out

## Operation
- Reset: the accumulator, shadow FTW, active FTW, shadow offset, active offset, `phase` and `wrap` all go to 0. With dither enabled, the LFSR goes to 16'hACE1.
- Config path:
  - When `cfg_we` = 1, the selected shadow byte is written. This ignores `ena`.
  - When `commit` = 1, the active registers take the pre-edge shadow values. A write in the same cycle reaches the shadow register only; it goes live on the next commit.
  - Shadow writes without a commit have no effect on the output.
- Accumulate, when `ena` = 1:
  - acc ← (acc + ftw_active) mod 2^ACC_W.
  - `wrap` ← the carry-out of that addition.
  - `phase` ← (acc[ACC_W-1 -: PHASE_W] + (off_active << (PHASE_W-8))) mod 2^PHASE_W. This uses the pre-edge `acc` and the pre-edge `off_active`.
- `sync` = 1 (only honoured when `ena` = 1):
  - acc ← 0 and `wrap` ← 0.
  - `phase` is still computed from the pre-edge `acc`.
  - `sync` and `commit` together: both take effect. The accumulator restarts from 0 and uses the new FTW from the next cycle.
- `ena` = 0: the accumulator and `phase` hold, and `wrap` ← 0.
- FTW = 0 gives a constant phase. FTW = 2^(ACC_W-1) alternates two phases 180° apart. Overflow always wraps modulo 2^ACC_W.

## Timing
- Latency from `commit` to a new step size: the accumulator uses the new FTW on the edge after the commit edge. `phase` reflects that one further cycle later.
- Offset change: visible on `phase` at the edge after the commit edge.
- `wrap` is a registered output, aligned with the `phase` value computed from the pre-wrap accumulator.
- Reset deassertion needs no synchronizer inside the block; the integrator is responsible for that. The first accumulate happens on the first `ena` edge after `rst` falls.

## Configuration
- DDS_PHASE_DITHER_EN defined:
  - A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11) advances every `ena` cycle.
  - Its low (ACC_W-PHASE_W) bits are added to `acc` before truncation, and the sum is taken mod 2^ACC_W.
- DDS_PHASE_DITHER_EN undefined: plain truncation, and no LFSR is instantiated.
- The ports are identical in both builds.

## Structure
- Shared package `dds_pkg` holds:
  - ACC_W and PHASE_W defaults
  - the cfg_addr encodings (ADDR_FTW0..2, ADDR_OFF)
  - LFSR seed and tap constants
- One sub-module, `dds_lfsr` (16-bit Galois, seed/step/out), instantiated only under DDS_PHASE_DITHER_EN.

## Test plan
- Reset mid-run with `rst` pulsed asynchronously between edges → `phase`=0 and `wrap`=0 immediately; registers read back as 0 after commit with no writes.
- FTW=24'h000400, commit, `ena`=1 → `phase` steps 0,1,2,… by 1 per cycle. `wrap` pulses exactly once every 16384 cycles, when `phase` goes 14'h3FFF→0.
- FTW=24'h800000, commit → `phase` alternates 0, 14'h2000. `wrap` pulses every second cycle.
- With FTW=24'h000400 running, write offset 8'h40 and commit → `phase` jumps by +14'h1000 relative to the non-offset sequence, with the latency given under Timing.
- Shadow-only write of FTW=24'h000800 with no commit → step stays 1. Write plus commit in the same cycle → still 1. Commit on the next cycle → step 2.
- `ena`=0 for 5 cycles mid-run → `phase` holds and `wrap`=0. `sync`+`ena` → accumulator restarts at 0. In dither builds, FTW=0 gives `phase` within ±1 LSB of the offset.
